// File: rtl/wavetable_loader_if.sv
// Shared sizing for the wavetable store, plus the loader's port bundle:
// sample stream in, RAM write port and bank status out.
package mypackage;
  localparam int WAVETABLE_N    = 4;
  localparam int AMPLITUDE_BITS = 16;
endpackage

interface wavetable_loader_if #(
  parameter int WAVETABLE_N    = mypackage::WAVETABLE_N,
  parameter int AMPLITUDE_BITS = mypackage::AMPLITUDE_BITS
);
  logic                      load_start;
  logic                      in_valid;
  logic                      in_ready;
  logic [AMPLITUDE_BITS-1:0] in_sample;
  logic                      in_last;
  logic                      swap_tick;
  logic                      wr_en;
  logic                      wr_bank;
  logic [WAVETABLE_N-1:0]    wr_addr;
  logic [AMPLITUDE_BITS-1:0] wr_data;
  logic                      active_bank;
  logic                      busy;
  logic                      done;
  logic                      error;

  modport master (
    output load_start, in_valid, in_sample, in_last, swap_tick,
    input  in_ready, wr_en, wr_bank, wr_addr, wr_data,
    input  active_bank, busy, done, error
  );

  modport slave (
    input  load_start, in_valid, in_sample, in_last, swap_tick,
    output in_ready, wr_en, wr_bank, wr_addr, wr_data,
    output active_bank, busy, done, error
  );
endinterface

// File: rtl/wavetable_loader.sv
// Fills the inactive bank of a two-bank wavetable RAM from a sample stream and
// flips active_bank on a sample-rate tick once a complete table has landed.
module wavetable_loader #(
  parameter int WAVETABLE_N    = mypackage::WAVETABLE_N,
  parameter int AMPLITUDE_BITS = mypackage::AMPLITUDE_BITS
) (
  input  logic             clock,
  input  logic             reset_n,
  wavetable_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_e;

  localparam logic [WAVETABLE_N-1:0] ADDR_LAST = '1;

  state_e                    state_q, state_d;
  logic [WAVETABLE_N-1:0]    addr_q, addr_d;
  logic                      target_q, target_d;
  logic                      active_q, active_d;
  logic                      wr_en_q, wr_en_d;
  logic                      wr_bank_q, wr_bank_d;
  logic [WAVETABLE_N-1:0]    wr_addr_q, wr_addr_d;
  logic [AMPLITUDE_BITS-1:0] wr_data_q, wr_data_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic                      in_ready_c;
  logic                      accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      target_q  <= 1'b0;
      active_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      target_q  <= target_d;
      active_q  <= active_d;
      wr_en_q   <= wr_en_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    target_d   = target_q;
    active_d   = active_q;
    wr_en_d    = 1'b0;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    in_ready_c = 1'b0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        // load_start wins over a coincident swap_tick: nothing is pending here.
        if (bus.load_start) begin
          state_d  = LOAD;
          addr_d   = '0;
          target_d = ~active_q;
        end
      end

      LOAD: begin
        in_ready_c = 1'b1;
        accept     = bus.in_valid;
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_bank_d = target_q;
          wr_addr_d = addr_q;
          wr_data_d = bus.in_sample;
          addr_d    = addr_q + 1'b1;
          // Length mismatch in either direction drops the table; the stray
          // write only touches the bank the reader is not using.
          if ((addr_q == ADDR_LAST) && bus.in_last) begin
            state_d = WAIT_SWAP;
          end else if ((addr_q == ADDR_LAST) || bus.in_last) begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end

      WAIT_SWAP: begin
        if (bus.swap_tick) begin
          active_d = ~active_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.active_bank = active_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_wavetable_loader.sv
// Directed bench for wavetable_loader: full loads, gapped stream, short/long
// tables, reset mid-load and ignored control pulses.
module tb_wavetable_loader;
  localparam int N  = 4;
  localparam int AB = 16;

  typedef struct {
    logic          bank;
    logic [N-1:0]  addr;
    logic [AB-1:0] data;
    int            cyc;
  } wr_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   done_cnt = 0;
  logic exp_active = 1'b0;
  wr_t  wq[$];

  wavetable_loader_if #(.WAVETABLE_N(N), .AMPLITUDE_BITS(AB)) bus();

  wavetable_loader #(.WAVETABLE_N(N), .AMPLITUDE_BITS(AB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.wr_en === 1'b1) wq.push_back('{bus.wr_bank, bus.wr_addr, bus.wr_data, cyc});
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_sample  = '0;
    bus.in_last    = 1'b0;
    bus.swap_tick  = 1'b0;
  endtask

  task automatic load_table(input int n, input int last_at, input bit gap,
                            input logic [AB-1:0] base, input int noise_at,
                            input bit tick_on_last);
    int waitc;
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      waitc = 0;
      while (bus.in_ready !== 1'b1 && waitc < 8) begin
        step();
        waitc++;
      end
      if (bus.in_ready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout sample %0d got %b want 1", i, bus.in_ready);
      end
      bus.in_valid   = 1'b1;
      bus.in_sample  = base + AB'(i);
      bus.in_last    = (i == last_at);
      bus.load_start = (i == noise_at);
      bus.swap_tick  = (i == noise_at) || (tick_on_last && (i == n - 1));
      step();
      bus.in_valid   = 1'b0;
      bus.in_last    = 1'b0;
      bus.load_start = 1'b0;
      bus.swap_tick  = 1'b0;
      if (gap && (i != n - 1)) step();
    end
  endtask

  task automatic test_reset();
    logic [AB+N+7:0] outs;
    idle_inputs();
    #2 reset_n = 1'b0;
    step();
    step();
    outs = {bus.in_ready, bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_data,
            bus.active_bank, bus.busy, bus.done, bus.error};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", outs);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b in_ready=%b want 0 0", bus.busy, bus.in_ready);
    end
    exp_active = 1'b0;
  endtask

  task automatic test_full_load();
    for (int rep = 0; rep < 2; rep++) begin
      wq.delete();
      load_table(16, 15, 1'b0, AB'(rep * 16'h0100), -1, rep == 1);
      checks++;
      if (bus.busy !== 1'b1 || bus.error !== 1'b0 || bus.done !== 1'b0 ||
          bus.active_bank !== exp_active) begin
        errors++;
        $display("FAIL full_wait_swap rep%0d got busy=%b err=%b done=%b act=%b want 1 0 0 %b",
                 rep, bus.busy, bus.error, bus.done, bus.active_bank, exp_active);
      end
      // A further cycle in WAIT_SWAP with no tick must keep the bank.
      step();
      checks++;
      if (bus.active_bank !== exp_active || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL full_hold rep%0d got act=%b busy=%b want %b 1", rep, bus.active_bank, bus.busy, exp_active);
      end
      bus.swap_tick = 1'b1;
      step();
      bus.swap_tick = 1'b0;
      exp_active = ~exp_active;
      checks++;
      if (bus.done !== 1'b1 || bus.active_bank !== exp_active || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL full_swap rep%0d got done=%b act=%b busy=%b want 1 %b 0",
                 rep, bus.done, bus.active_bank, bus.busy, exp_active);
      end
      checks++;
      if (wq.size() != 16) begin
        errors++;
        $display("FAIL full_write_count rep%0d got %0d want 16", rep, wq.size());
      end else begin
        for (int i = 0; i < 16; i++) begin
          checks++;
          if (wq[i].addr !== N'(i) || wq[i].data !== AB'(rep * 16'h0100 + i) ||
              wq[i].bank !== exp_active || wq[i].cyc != wq[0].cyc + i) begin
            errors++;
            $display("FAIL full_write rep%0d idx%0d got bank=%b addr=%h data=%h dcyc=%0d want %b %h %h %0d",
                     rep, i, wq[i].bank, wq[i].addr, wq[i].data, wq[i].cyc - wq[0].cyc,
                     exp_active, N'(i), AB'(rep * 16'h0100 + i), i);
          end
        end
      end
      step();
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL full_done_pulse rep%0d got %b want 0", rep, bus.done);
      end
    end
  endtask

  task automatic test_gapped_stream();
    wq.delete();
    load_table(16, 15, 1'b1, 16'h0A00, -1, 1'b0);
    bus.swap_tick = 1'b1;
    step();
    bus.swap_tick = 1'b0;
    exp_active = ~exp_active;
    checks++;
    if (bus.done !== 1'b1 || bus.active_bank !== exp_active) begin
      errors++;
      $display("FAIL gap_swap got done=%b act=%b want 1 %b", bus.done, bus.active_bank, exp_active);
    end
    checks++;
    if (wq.size() != 16) begin
      errors++;
      $display("FAIL gap_write_count got %0d want 16", wq.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (wq[i].addr !== N'(i) || wq[i].data !== (16'h0A00 + AB'(i)) ||
            wq[i].bank !== exp_active || wq[i].cyc != wq[0].cyc + 2 * i) begin
          errors++;
          $display("FAIL gap_write idx%0d got bank=%b addr=%h data=%h dcyc=%0d want %b %h %h %0d",
                   i, wq[i].bank, wq[i].addr, wq[i].data, wq[i].cyc - wq[0].cyc,
                   exp_active, N'(i), 16'h0A00 + AB'(i), 2 * i);
        end
      end
    end
    step();
  endtask

  task automatic test_short_table();
    wq.delete();
    load_table(5, 4, 1'b0, 16'h0000, -1, 1'b0);
    checks++;
    if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.active_bank !== exp_active) begin
      errors++;
      $display("FAIL short_abort got err=%b busy=%b act=%b want 1 0 %b",
               bus.error, bus.busy, bus.active_bank, exp_active);
    end
    step();
    checks++;
    if (bus.error !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL short_err_pulse got err=%b in_ready=%b want 0 0", bus.error, bus.in_ready);
    end
    checks++;
    if (wq.size() != 5 || wq[wq.size()-1].data !== 16'h0004 || wq[wq.size()-1].bank !== ~exp_active) begin
      errors++;
      $display("FAIL short_writes got count=%0d want 5 with last data 0004 in inactive bank", wq.size());
    end
    bus.swap_tick = 1'b1;
    step();
    bus.swap_tick = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.active_bank !== exp_active) begin
      errors++;
      $display("FAIL short_no_flip got done=%b act=%b want 0 %b", bus.done, bus.active_bank, exp_active);
    end
    step();
  endtask

  task automatic test_long_table();
    wq.delete();
    load_table(16, -1, 1'b0, 16'h0200, -1, 1'b0);
    checks++;
    if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL long_abort got err=%b busy=%b want 1 0", bus.error, bus.busy);
    end
    step();
    checks++;
    if (bus.error !== 1'b0 || wq.size() != 16) begin
      errors++;
      $display("FAIL long_after got err=%b writes=%0d want 0 16", bus.error, wq.size());
    end
    bus.swap_tick = 1'b1;
    step();
    bus.swap_tick = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.active_bank !== exp_active) begin
      errors++;
      $display("FAIL long_no_flip got done=%b act=%b want 0 %b", bus.done, bus.active_bank, exp_active);
    end
    step();
  endtask

  task automatic test_reset_mid_load();
    logic [AB+N+7:0] outs;
    wq.delete();
    load_table(8, -1, 1'b0, 16'h0300, -1, 1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.wr_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_load_state got busy=%b wr_en=%b want 1 1", bus.busy, bus.wr_en);
    end
    reset_n = 1'b0;
    #1;
    outs = {bus.in_ready, bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_data,
            bus.active_bank, bus.busy, bus.done, bus.error};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL mid_load_reset got %h want 0", outs);
    end
    reset_n = 1'b1;
    exp_active = 1'b0;
    step();
    wq.delete();
    load_table(16, 15, 1'b0, 16'h0400, -1, 1'b0);
    bus.swap_tick = 1'b1;
    step();
    bus.swap_tick = 1'b0;
    exp_active = 1'b1;
    checks++;
    if (bus.done !== 1'b1 || bus.active_bank !== 1'b1 || wq.size() != 16 || wq[0].bank !== 1'b1) begin
      errors++;
      $display("FAIL reload_after_reset got done=%b act=%b writes=%0d want 1 1 16",
               bus.done, bus.active_bank, wq.size());
    end
    step();
  endtask

  task automatic test_ignored_pulses();
    int done_before;
    done_before = done_cnt;
    wq.delete();
    load_table(16, 15, 1'b0, 16'h0500, 5, 1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.active_bank !== exp_active || done_cnt != done_before) begin
      errors++;
      $display("FAIL noise_during_load got busy=%b act=%b dones=%0d want 1 %b 0",
               bus.busy, bus.active_bank, done_cnt - done_before, exp_active);
    end
    bus.swap_tick = 1'b1;
    step();
    bus.swap_tick = 1'b0;
    exp_active = ~exp_active;
    checks++;
    if (bus.done !== 1'b1 || bus.active_bank !== exp_active) begin
      errors++;
      $display("FAIL noise_swap got done=%b act=%b want 1 %b", bus.done, bus.active_bank, exp_active);
    end
    checks++;
    if (wq.size() != 16) begin
      errors++;
      $display("FAIL noise_write_count got %0d want 16", wq.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (wq[i].addr !== N'(i) || wq[i].data !== (16'h0500 + AB'(i)) || wq[i].bank !== exp_active) begin
          errors++;
          $display("FAIL noise_write idx%0d got bank=%b addr=%h data=%h want %b %h %h",
                   i, wq[i].bank, wq[i].addr, wq[i].data, exp_active, N'(i), 16'h0500 + AB'(i));
        end
      end
    end
    step();
  endtask

  task automatic test_idle_collision();
    bus.load_start = 1'b1;
    bus.swap_tick  = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.swap_tick  = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.done !== 1'b0 ||
        bus.active_bank !== exp_active) begin
      errors++;
      $display("FAIL idle_collision got busy=%b rdy=%b done=%b act=%b want 1 1 0 %b",
               bus.busy, bus.in_ready, bus.done, bus.active_bank, exp_active);
    end
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'h0BAD;
    bus.in_last   = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (bus.error !== 1'b1 || bus.wr_en !== 1'b1 || bus.wr_bank !== ~exp_active ||
        bus.wr_addr !== '0 || bus.wr_data !== 16'h0BAD) begin
      errors++;
      $display("FAIL collision_abort got err=%b wr_en=%b bank=%b addr=%h data=%h want 1 1 %b 0 0bad",
               bus.error, bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_data, ~exp_active);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gapped_stream();
    test_short_table();
    test_long_table();
    test_reset_mid_load();
    test_ignored_pulses();
    test_idle_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end
endmodule
